// File: rtl/ibex_hpm_counter_bank.sv
// Bank of CSR-writable hardware performance counters with per-channel event
// select, count inhibit, sticky overflow flags and a registered readout port.
module ibex_hpm_counter_bank #(
    parameter  int unsigned NumCounters  = 4,
    parameter  int unsigned CounterWidth = 40,
    parameter  int unsigned NumEvents    = 16,
    localparam int unsigned IdxW         = (NumCounters > 1) ? $clog2(NumCounters) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   setback_i,
    input  logic [NumEvents-1:0]   event_i,
    input  logic [NumCounters-1:0] inhibit_i,
    input  logic [IdxW-1:0]        wr_idx_i,
    input  logic                   sel_we_i,
    input  logic [NumEvents-1:0]   sel_val_i,
    input  logic                   counter_we_i,
    input  logic                   counterh_we_i,
    input  logic [31:0]            counter_val_i,
    input  logic [NumCounters-1:0] ovf_clr_i,
    input  logic [IdxW-1:0]        rd_idx_i,
    output logic [63:0]            rd_val_o,
    output logic [NumCounters-1:0] ovf_o
);

    logic [CounterWidth-1:0] cnt_vals [NumCounters];

    for (genvar gi = 0; gi < NumCounters; gi++) begin : g_chan
        logic [NumEvents-1:0]    sel_q;
        logic [CounterWidth-1:0] cnt_q;
        logic [CounterWidth-1:0] cnt_d;
        logic [CounterWidth-1:0] wr_val;
        logic                    ovf_q;
        logic                    ovf_d;
        logic                    addr_hit;
        logic                    wr_en;
        logic                    inc;

        // Out-of-range write indices never match any channel, so they are dropped.
        assign addr_hit = (wr_idx_i == IdxW'(gi));
        assign wr_en    = addr_hit & (counter_we_i | counterh_we_i);
        assign inc      = (|(event_i & sel_q)) & ~inhibit_i[gi];

        // Merge the 32-bit write data into the addressed half; bits 32..63 map
        // onto counter_val_i[b-32], which equals b % 32 in that range.
        always_comb begin
            wr_val = cnt_q;
            for (int b = 0; b < int'(CounterWidth); b++) begin
                if (b >= 32) begin
                    wr_val[b] = counterh_we_i ? counter_val_i[b % 32] : cnt_q[b];
                end else begin
                    wr_val[b] = counterh_we_i ? cnt_q[b] : counter_val_i[b % 32];
                end
            end
        end

        always_comb begin
            cnt_d = cnt_q;
            ovf_d = ovf_q & ~ovf_clr_i[gi];
            if (setback_i) begin
                cnt_d = '0;
                ovf_d = 1'b0;
            end else if (wr_en) begin
                cnt_d = wr_val;
                ovf_d = 1'b0;
            end else if (inc) begin
                cnt_d = cnt_q + CounterWidth'(1);
                // A wrap beats a same-cycle flag clear.
                if (&cnt_q) begin
                    ovf_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                ovf_q <= ovf_d;
            end
        end

        // Event masks survive setback so counting resumes with the same selection.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sel_q <= '0;
            end else if (sel_we_i && addr_hit) begin
                sel_q <= sel_val_i;
            end
        end

        assign cnt_vals[gi] = cnt_q;
        assign ovf_o[gi]    = ovf_q;
    end

    logic [63:0] rd_val_q;
    logic [63:0] rd_val_d;

    always_comb begin
        rd_val_d = '0;
        for (int i = 0; i < int'(NumCounters); i++) begin
            if (rd_idx_i == IdxW'(i)) begin
                rd_val_d = 64'(cnt_vals[i]);
            end
        end
        if (setback_i) begin
            rd_val_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_val_q <= '0;
        end else begin
            rd_val_q <= rd_val_d;
        end
    end

    assign rd_val_o = rd_val_q;

endmodule

// File: tb/tb_ibex_hpm_counter_bank.sv
// Scoreboard bench for ibex_hpm_counter_bank: directed stimulus queues expected
// readouts; a monitor compares rd_val_o / ovf_o one cycle after each read request.
module tb_ibex_hpm_counter_bank;

    localparam int NC = 5;
    localparam int CW = 40;
    localparam int NE = 16;
    localparam int IW = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          setback_i = 1'b0;
    logic [NE-1:0] event_i = '0;
    logic [NC-1:0] inhibit_i = '0;
    logic [IW-1:0] wr_idx_i = '0;
    logic          sel_we_i = 1'b0;
    logic [NE-1:0] sel_val_i = '0;
    logic          counter_we_i = 1'b0;
    logic          counterh_we_i = 1'b0;
    logic [31:0]   counter_val_i = '0;
    logic [NC-1:0] ovf_clr_i = '0;
    logic [IW-1:0] rd_idx_i = '0;
    logic [63:0]   rd_val_o;
    logic [NC-1:0] ovf_o;

    ibex_hpm_counter_bank #(
        .NumCounters (NC),
        .CounterWidth(CW),
        .NumEvents   (NE)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .setback_i    (setback_i),
        .event_i      (event_i),
        .inhibit_i    (inhibit_i),
        .wr_idx_i     (wr_idx_i),
        .sel_we_i     (sel_we_i),
        .sel_val_i    (sel_val_i),
        .counter_we_i (counter_we_i),
        .counterh_we_i(counterh_we_i),
        .counter_val_i(counter_val_i),
        .ovf_clr_i    (ovf_clr_i),
        .rd_idx_i     (rd_idx_i),
        .rd_val_o     (rd_val_o),
        .ovf_o        (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0]   exp_val_q  [$];
    logic [NC-1:0] exp_ovf_q  [$];
    string         exp_name_q [$];

    logic rd_req = 1'b0;
    logic rd_valid_q = 1'b0;

    always @(posedge clk_i) rd_valid_q <= rd_req;

    // Monitor: each registered readout is compared against the oldest expectation.
    always @(negedge clk_i) begin
        if (rd_valid_q) begin
            if (exp_val_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_read: got rd_val_o=%h with no expectation queued", rd_val_o);
            end else begin
                logic [63:0]   ev;
                logic [NC-1:0] eo;
                string         nm;
                ev = exp_val_q.pop_front();
                eo = exp_ovf_q.pop_front();
                nm = exp_name_q.pop_front();
                n_checks++;
                if (rd_val_o !== ev) begin
                    n_fail++;
                    $display("FAIL %s rd_val_o: got %h expected %h", nm, rd_val_o, ev);
                end else begin
                    $display("ok   %s rd_val_o=%h", nm, rd_val_o);
                end
                n_checks++;
                if (ovf_o !== eo) begin
                    n_fail++;
                    $display("FAIL %s ovf_o: got %b expected %b", nm, ovf_o, eo);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic rd(input int idx, input logic [63:0] v, input logic [NC-1:0] o, input string nm);
        rd_idx_i = IW'(idx);
        rd_req   = 1'b1;
        exp_val_q.push_back(v);
        exp_ovf_q.push_back(o);
        exp_name_q.push_back(nm);
        cyc(1);
        rd_req = 1'b0;
    endtask

    task automatic wsel(input int idx, input logic [NE-1:0] val);
        wr_idx_i  = IW'(idx);
        sel_val_i = val;
        sel_we_i  = 1'b1;
        cyc(1);
        sel_we_i  = 1'b0;
    endtask

    task automatic wcnt(input int idx, input logic hi, input logic lo, input logic [31:0] val);
        wr_idx_i      = IW'(idx);
        counterh_we_i = hi;
        counter_we_i  = lo;
        counter_val_i = val;
        cyc(1);
        counterh_we_i = 1'b0;
        counter_we_i  = 1'b0;
    endtask

    task automatic run_ev(input logic [NE-1:0] ev, input int n);
        event_i = ev;
        cyc(n);
        event_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state while rst_ni is held low, events toggling.
        for (int i = 0; i < 4; i++) begin
            event_i = NE'($urandom);
            cyc(1);
        end
        rd(0, 64'h0, 5'b00000, "reset_hold_ch0");
        rd(3, 64'h0, 5'b00000, "reset_hold_ch3");
        event_i = '0;
        rst_ni  = 1'b1;
        cyc(1);

        // No selects after reset: toggling events must not count.
        for (int i = 0; i < 20; i++) begin
            event_i = NE'($urandom);
            cyc(1);
        end
        event_i = '0;
        for (int i = 0; i < NC; i++) rd(i, 64'h0, 5'b00000, "after_reset_idle");

        // Channel 1 counts bit2 hits only: 10 hits, then 5 unselected cycles.
        wsel(1, 16'h0005);
        run_ev(16'h0004, 10);
        run_ev(16'h0002, 5);
        rd(1, 64'd10, 5'b00000, "ch1_count10");
        rd(0, 64'd0,  5'b00000, "ch0_unselected");

        // Channel 2 same mask, inhibited for first 3 cycles; ch1 keeps counting.
        wsel(2, 16'h0005);
        event_i   = 16'h0004;
        inhibit_i = 5'b00100;
        cyc(3);
        inhibit_i = '0;
        cyc(7);
        run_ev(16'h0002, 5);
        rd(1, 64'd20, 5'b00000, "ch1_count20");
        rd(2, 64'd7,  5'b00000, "ch2_inhibit7");

        // Channel 3 wrap at 40 bits with flag clear in the wrap cycle.
        wsel(3, 16'h0008);
        wcnt(3, 1'b1, 1'b0, 32'h0000_00FF);
        wcnt(3, 1'b0, 1'b1, 32'hFFFF_FFFE);
        rd(3, 64'h0000_00FF_FFFF_FFFE, 5'b00000, "ch3_preset");
        event_i = 16'h0008;
        cyc(1);
        ovf_clr_i = 5'b01000;
        cyc(1);
        ovf_clr_i = '0;
        cyc(1);
        event_i = '0;
        rd(3, 64'h1,  5'b01000, "ch3_wrapped");
        rd(1, 64'd20, 5'b01000, "ch1_unaffected");

        // A counter write clears the flag.
        wcnt(3, 1'b0, 1'b1, 32'h0000_0055);
        rd(3, 64'h55, 5'b00000, "ch3_write_clears_ovf");

        // Write beats same-cycle increment.
        event_i       = 16'h0004;
        inhibit_i     = 5'b00100;
        wr_idx_i      = 3'd1;
        counter_we_i  = 1'b1;
        counter_val_i = 32'h0000_1234;
        cyc(1);
        event_i      = '0;
        inhibit_i    = '0;
        counter_we_i = 1'b0;
        rd(1, 64'h1234, 5'b00000, "ch1_write_over_inc");
        rd(2, 64'd7,    5'b00000, "ch2_inhibited_hold");

        // Both write strobes: high half wins, low half kept.
        wcnt(2, 1'b1, 1'b1, 32'h0000_00AB);
        rd(2, 64'h0000_00AB_0000_0007, 5'b00000, "ch2_both_we");

        // Out-of-range write index and read index.
        wcnt(5, 1'b0, 1'b1, 32'h0000_DEAD);
        wcnt(5, 1'b1, 1'b0, 32'h0000_BEEF);
        rd(0, 64'h0,                   5'b00000, "oor_ch0");
        rd(1, 64'h1234,                5'b00000, "oor_ch1");
        rd(3, 64'h55,                  5'b00000, "oor_ch3");
        rd(4, 64'h0,                   5'b00000, "oor_ch4");
        rd(2, 64'h0000_00AB_0000_0007, 5'b00000, "oor_ch2");
        rd(5, 64'h0,                   5'b00000, "rd_idx5");
        rd(1, 64'h1234,                5'b00000, "oor_ch1_again");
        rd(7, 64'h0,                   5'b00000, "rd_idx7");

        // All channels to all-ones, wrap, then one more hit: nonzero and flagged.
        wsel(0, 16'h0010);
        wsel(4, 16'h0010);
        for (int i = 0; i < NC; i++) begin
            wcnt(i, 1'b1, 1'b0, 32'h0000_00FF);
            wcnt(i, 1'b0, 1'b1, 32'hFFFF_FFFF);
        end
        run_ev(16'h001C, 2);
        for (int i = 0; i < NC; i++) rd(i, 64'h1, 5'b11111, "pre_setback");

        setback_i = 1'b1;
        cyc(1);
        setback_i = 1'b0;
        for (int i = 0; i < NC; i++) rd(i, 64'h0, 5'b00000, "post_setback");

        // Select masks survive setback.
        run_ev(16'h001C, 2);
        for (int i = 0; i < NC; i++) rd(i, 64'h2, 5'b00000, "resume_after_setback");

        cyc(3);
        if (exp_val_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_val_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_hpm_counter_bank.md
# ibex_hpm_counter_bank

Parametrised bank of hardware performance counters that generalises the single CSR-writable counter to N independent channels. Each channel counts cycles in which any of its selected events fire, supports 32-bit CSR writes to low/high halves, and raises a sticky overflow flag on wrap-around. It sits beside the CSR file, which drives the write, select, inhibit and read-index inputs and consumes the registered read data and overflow flags.

## Interface
- NumCounters, 4, number of channels (1..29)
- CounterWidth, 40, implemented bits per channel (1..64); bits above read as zero
- NumEvents, 16, width of the event input vector (1..32)
- IdxW, derived, $clog2(NumCounters) rounded up to at least 1; not user-overridable
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- setback_i  in  1  synchronous clear of all channel state
- event_i  in  NumEvents  per-cycle event strobes
- inhibit_i  in  NumCounters  per-channel count inhibit (mcountinhibit style)
- wr_idx_i  in  IdxW  channel addressed by all write strobes
- sel_we_i  in  1  write event-select mask of channel wr_idx_i
- sel_val_i  in  NumEvents  event-select mask value
- counter_we_i  in  1  write low 32 bits of channel wr_idx_i
- counterh_we_i  in  1  write bits 63:32 of channel wr_idx_i
- counter_val_i  in  32  write data for counter writes
- ovf_clr_i  in  NumCounters  per-channel overflow-flag clear
- rd_idx_i  in  IdxW  channel selected for readout
- rd_val_o  out  64  registered, zero-extended value of channel rd_idx_i
- ovf_o  out  NumCounters  sticky overflow flags

## Operation
- Per channel i: hit_i = |(event_i & sel_q[i]); inc_i = hit_i & ~inhibit_i[i].
- Next-value priority per channel: setback_i > write (addressed, index in range) > increment > hold.
- Write data: counterh_we_i replaces bits 63:32 and keeps 31:0; otherwise counter_we_i replaces 31:0 and keeps 63:32. Both asserted: counterh_we_i wins. Result is truncated to CounterWidth; with CounterWidth <= 32 a high write leaves the channel unchanged.
- Increment: CounterWidth-bit add of 1, modulo 2^CounterWidth. Value all-ones with inc_i -> 0 and ovf_q[i] set.
- ovf_q[i]: set on wrap; cleared by ovf_clr_i[i], by any counter write to channel i, or by setback_i. Same-cycle wrap and ovf_clr_i: set wins. A write to channel i in the same cycle suppresses the increment, so no wrap occurs.
- sel_q[i] is written by sel_we_i when wr_idx_i == i. It is cleared only by reset, not by setback_i. A select write and a counter write may occur in the same cycle.
- wr_idx_i or rd_idx_i >= NumCounters: writes are ignored; the read returns 0.
- Reset and setback values: all counters 0, ovf_o 0, rd_val_o 0. Reset also clears sel_q to 0, so no channel counts after reset.

## Timing
- All state is updated on the rising edge of clk_i. rst_ni clears all state asynchronously. Assertion mid-count discards in-flight updates.
- Write or increment in cycle N -> channel value updated at edge N+1.
- rd_val_o is registered from rd_idx_i and the current channel value. The value written in cycle N appears on rd_val_o in cycle N+2 if rd_idx_i selects that channel in cycle N+1.
- ovf_o is taken directly from flops: a wrap in cycle N is visible in cycle N+1.
- Event select written in cycle N affects counting from cycle N+1.
- setback_i in cycle N: counters, flags and rd_val_o are 0 from cycle N+1.

## Test plan
- Reset with sel_q = 0 and event_i toggling for 20 cycles -> all channels read 0 and ovf_o = 0.
- Channel 1: sel = 0x0005, event_i = 0x0004 for 10 cycles, then 0x0002 for 5 cycles -> reads 10. Setting inhibit_i[1] for the first 3 cycles -> reads 7.
- CounterWidth = 40: write high half 0xFF and low half 0xFFFFFFFE, then 3 hits -> reads 0x0000_0000_0000_0001 and ovf_o[ch] = 1. Asserting ovf_clr_i in the wrap cycle -> flag still 1.
- Counter write of 0x1234 in the same cycle as a hit -> reads 0x1234, not 0x1235. counter_we_i and counterh_we_i together with value 0xAB -> high half 0xAB, low half unchanged.
- wr_idx_i = NumCounters with counter_we_i -> no channel changes. rd_idx_i = NumCounters -> rd_val_o = 0 in the next cycle.
- setback_i while all channels are nonzero and flagged -> all reads 0 and ovf_o = 0 the next cycle. Counting then resumes with the previous select masks.
